argmax_classifier: RTL and testbench

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

---
 rtl/vad_pkg.sv | 15 +
 rtl/vad_hangover.sv | 36 +++
 rtl/argmax_classifier.sv | 115 +++++++++++
 tb/tb_argmax_classifier.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/vad_pkg.sv
// Shared types and default sizing for the argmax classifier / VAD block.
// FSM state encoding and default parameter values live here.
package vad_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_CLASS_DEF     = 2;
    localparam int SCORE_W_DEF     = 8;
    localparam int HANG_FRAMES_DEF = 4;

endpackage

// File: rtl/vad_hangover.sv
// Hangover smoothing of the speech decision: holds vad_flag high for
// HANG_FRAMES non-speech results after the last speech result.
module vad_hangover
    import vad_pkg::*;
#(
    parameter int HANG_FRAMES = HANG_FRAMES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic update,
    input  logic speech,
    output logic vad_flag
);

    localparam int CW = (HANG_FRAMES < 1) ? 1 : $clog2(HANG_FRAMES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            vad_flag <= 1'b0;
        end else if (update) begin
            if (speech) begin
                cnt      <= CW'(HANG_FRAMES);
                vad_flag <= 1'b1;
            end else if (cnt != '0) begin
                cnt      <= cnt - 1'b1;
                vad_flag <= 1'b1;
            end else begin
                vad_flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/argmax_classifier.sv
// Sequential argmax over N_CLASS signed scores with a speech/VAD flag.
// Define VAD_HANG_EN to enable hangover smoothing of vad_flag.
module argmax_classifier
    import vad_pkg::*;
#(
    parameter int N_CLASS      = N_CLASS_DEF,
    parameter int SCORE_W      = SCORE_W_DEF,
    parameter int SPEECH_CLASS = 0,
    parameter int HANG_FRAMES  = HANG_FRAMES_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N_CLASS*SCORE_W-1:0] scores_in,
    output logic                       busy,
    output logic                       result_valid,
    output logic [$clog2(N_CLASS)-1:0] class_idx,
    output logic [N_CLASS-1:0]         class_onehot,
    output logic [SCORE_W-1:0]         max_score,
    output logic                       vad_flag
);

    localparam int IW = $clog2(N_CLASS);
    localparam logic [IW-1:0] LAST = IW'(N_CLASS - 1);
    localparam logic [IW-1:0] SPEECH_IDX = IW'(SPEECH_CLASS);

    if (N_CLASS < 2 || HANG_FRAMES < 1) begin : g_bad_cfg
        $error("argmax_classifier: bad N_CLASS or HANG_FRAMES");
    end

    state_t                     state;
    logic [N_CLASS*SCORE_W-1:0] sv;
    logic signed [SCORE_W-1:0]  best;
    logic signed [SCORE_W-1:0]  cur;
    logic [IW-1:0]              idx;
    logic [IW-1:0]              cnt;
    logic [N_CLASS-1:0]         oh;
    logic                       done;
    logic                       is_speech;

    assign cur       = sv[int'(cnt)*SCORE_W +: SCORE_W];
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign is_speech = (idx == SPEECH_IDX);

    always_comb begin
        oh      = '0;
        oh[idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sv           <= '0;
            best         <= '0;
            idx          <= '0;
            cnt          <= '0;
            result_valid <= 1'b0;
            class_idx    <= '0;
            class_onehot <= '0;
            max_score    <= '0;
        end else begin
            result_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sv    <= scores_in;
                        best  <= scores_in[SCORE_W-1:0];
                        idx   <= '0;
                        cnt   <= IW'(1);
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    // strict compare keeps the lowest index on ties
                    if (cur > best) begin
                        best <= cur;
                        idx  <= cnt;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= DONE;
                end
                DONE: begin
                    result_valid <= 1'b1;
                    class_idx    <= idx;
                    class_onehot <= oh;
                    max_score    <= best;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VAD_HANG_EN
    vad_hangover #(
        .HANG_FRAMES(HANG_FRAMES)
    ) u_hang (
        .clk     (clk),
        .rst     (rst),
        .update  (done),
        .speech  (is_speech),
        .vad_flag(vad_flag)
    );
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vad_flag <= 1'b0;
        else if (done)
            vad_flag <= is_speech;
    end
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: an N=2 and an N=4 instance
// sharing clock and reset.
module tb_argmax_classifier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start2 = 1'b0;
    logic [15:0] sc2 = '0;
    logic        busy2, rv2, vad2;
    logic [0:0]  idx2;
    logic [1:0]  oh2;
    logic [7:0]  max2;

    logic        start4 = 1'b0;
    logic [31:0] sc4 = '0;
    logic        busy4, rv4, vad4;
    logic [1:0]  idx4;
    logic [3:0]  oh4;
    logic [7:0]  max4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    argmax_classifier #(
        .N_CLASS(2), .SCORE_W(8), .SPEECH_CLASS(0), .HANG_FRAMES(4)
    ) d2 (
        .clk(clk), .rst(rst), .start(start2), .scores_in(sc2),
        .busy(busy2), .result_valid(rv2), .class_idx(idx2),
        .class_onehot(oh2), .max_score(max2), .vad_flag(vad2)
    );

    argmax_classifier #(
        .N_CLASS(4), .SCORE_W(8), .SPEECH_CLASS(0), .HANG_FRAMES(2)
    ) d4 (
        .clk(clk), .rst(rst), .start(start4), .scores_in(sc4),
        .busy(busy4), .result_valid(rv4), .class_idx(idx4),
        .class_onehot(oh4), .max_score(max4), .vad_flag(vad4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // one start pulse; returns edges from accept to result_valid, busy after accept
    task automatic run(input bit four, input logic [31:0] sc,
                       output int lat, output logic bz);
        if (four) begin
            sc4 = sc;
            start4 = 1'b1;
        end else begin
            sc2 = sc[15:0];
            start2 = 1'b1;
        end
        tick;
        start2 = 1'b0;
        start4 = 1'b0;
        bz = four ? busy4 : busy2;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            tick;
            if (four ? rv4 : rv2) begin
                lat = n;
                break;
            end
        end
    endtask

    int   lat;
    logic bz;
    int   nrv;
    logic [1:0] cap_idx;
    logic [7:0] cap_max;
    logic [3:0] hang_exp;

    initial begin
        tick;
        tick;
        chk("rst_busy", {busy2, busy4}, 0);
        chk("rst_rv", {rv2, rv4}, 0);
        chk("rst_idx", {idx2, idx4}, 0);
        chk("rst_oh", {oh2, oh4}, 0);
        chk("rst_max", {max2, max4}, 0);
        chk("rst_vad", {vad2, vad4}, 0);
        rst = 1'b0;

        // N=2 basic: s0=5, s1=-3
        run(1'b0, {16'h0, 8'hFD, 8'h05}, lat, bz);
        chk("n2_busy", bz, 1);
        chk("n2_lat", lat, 2);
        chk("n2_idx", idx2, 0);
        chk("n2_oh", oh2, 2'b01);
        chk("n2_max", max2, 8'h05);
        chk("n2_vad", vad2, 1);
        tick;
        chk("n2_rv_pulse", rv2, 0);
        chk("n2_idle", busy2, 0);
        chk("n2_hold_max", max2, 8'h05);

        // N=4 ties and sign: {-128,7,7,-1}
        run(1'b1, {8'hFF, 8'h07, 8'h07, 8'h80}, lat, bz);
        chk("tie_lat", lat, 4);
        chk("tie_idx", idx4, 1);
        chk("tie_oh", oh4, 4'b0010);
        chk("tie_max", max4, 8'h07);
        chk("tie_vad", vad4, 0);

        // all equal
        run(1'b1, {8'h03, 8'h03, 8'h03, 8'h03}, lat, bz);
        chk("eq_lat", lat, 4);
        chk("eq_idx", idx4, 0);
        chk("eq_max", max4, 8'h03);
        chk("eq_vad", vad4, 1);

        // busy rejection
        sc4 = {8'h00, 8'h02, 8'h09, 8'h01};
        start4 = 1'b1;
        tick;
        sc4 = {8'h00, 8'h00, 8'h00, 8'h14};
        nrv = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (rv4) nrv++;
        end
        start4 = 1'b0;
        cap_idx = '0;
        cap_max = '0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (rv4) begin
                nrv++;
                cap_idx = idx4;
                cap_max = max4;
            end
        end
        chk("rej_count", nrv, 1);
        chk("rej_idx", cap_idx, 1);
        chk("rej_max", cap_max, 8'h09);
`ifdef VAD_HANG_EN
        chk("rej_vad", vad4, 1);
`else
        chk("rej_vad", vad4, 0);
`endif

        // reset mid-scan
        sc4 = {8'h00, 8'h00, 8'h00, 8'h07};
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        tick;
        chk("mid_busy", busy4, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out", {busy4, rv4, idx4, oh4, max4, vad4}, 0);
        tick;
        rst = 1'b0;
        nrv = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (rv4) nrv++;
        end
        chk("mid_no_rv", nrv, 0);
        chk("mid_out", {busy4, idx4, oh4, max4, vad4}, 0);
        run(1'b1, {8'h00, 8'h00, 8'h09, 8'h00}, lat, bz);
        chk("post_lat", lat, 4);
        chk("post_idx", idx4, 1);
        chk("post_vad", vad4, 0);

        // hangover: speech, non, non, non
`ifdef VAD_HANG_EN
        hang_exp = 4'b1110;
`else
        hang_exp = 4'b1000;
`endif
        run(1'b1, {8'h00, 8'h00, 8'h00, 8'h09}, lat, bz);
        chk("hang0", vad4, hang_exp[3]);
        run(1'b1, {8'h00, 8'h00, 8'h09, 8'h00}, lat, bz);
        chk("hang1", vad4, hang_exp[2]);
        run(1'b1, {8'h00, 8'h09, 8'h00, 8'h00}, lat, bz);
        chk("hang2", vad4, hang_exp[1]);
        run(1'b1, {8'h09, 8'h00, 8'h00, 8'h00}, lat, bz);
        chk("hang3", vad4, hang_exp[0]);
        chk("hang3_idx", idx4, 3);
        chk("hang3_oh", oh4, 4'b1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
